// File: rtl/transmisor_if.sv
// Byte handshake and serial-line bundle for the transmisor serial transmitter.
// master drives bytes in; slave is the transmitter side.
interface transmisor_if;
   logic [7:0] data_in;
   logic       valid;
   logic       ready;
   logic       tx;
   logic       busy;
   logic       done;

   modport master (output data_in, output valid,
                   input ready, input tx, input busy, input done);
   modport slave  (input data_in, input valid,
                   output ready, output tx, output busy, output done);
endinterface

// File: rtl/transmisor.sv
// Serial transmitter: start bit, 8 data bits LSB first, optional parity bit, stop bit.
// One-entry holding register keeps frames back-to-back. Parity bit present when TX_PARITY_EN is defined.
module transmisor #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_ODD   = 1'b0
) (
   input logic         clk,
   input logic         rst,
   transmisor_if.slave bus
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(CLKS_PER_BIT - 2);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       bit_idx_r;
   logic [7:0]       shift_r;
   logic [7:0]       hold_r;
   logic             tx_r;
   logic             busy_r;
   logic             ready_r;
   logic             done_r;
   logic             accept_s;
   logic             bit_end_s;
   logic             load_hold_s;

`ifdef TX_PARITY_EN
   logic par_r;

   function automatic logic parity_of(input logic [7:0] b);
      return (^b) ^ PARITY_ODD;
   endfunction
`else
   logic parity_odd_unused_s;
   assign parity_odd_unused_s = PARITY_ODD;
`endif

   // Handshake and bit-timing decodes
   always_comb begin
      accept_s    = bus.valid && ready_r;
      bit_end_s   = (cnt_r == CNT_LAST);
      load_hold_s = 1'b0;
      // Bypass slots (IDLE, final STOP cycle) feed the shifter; everything else queues
      if (accept_s && (state_r != IDLE) && !((state_r == STOP) && bit_end_s)) begin
         load_hold_s = 1'b1;
      end else begin
         load_hold_s = 1'b0;
      end
   end

   // Frame sequencer, byte routing and registered line outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         hold_r    <= 8'h00;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
         ready_r   <= 1'b1;
         done_r    <= 1'b0;
`ifdef TX_PARITY_EN
         par_r     <= 1'b0;
`endif
      end else begin
         done_r <= (state_r == STOP) && (cnt_r == CNT_PRELAST);
         case (state_r)
            IDLE: begin
               cnt_r <= '0;
               if (accept_s) begin
                  shift_r <= bus.data_in;
`ifdef TX_PARITY_EN
                  par_r   <= parity_of(bus.data_in);
`endif
                  state_r <= START;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
               end else begin
                  tx_r    <= 1'b1;
                  busy_r  <= 1'b0;
               end
            end
            START: begin
               if (bit_end_s) begin
                  cnt_r     <= '0;
                  bit_idx_r <= 3'd0;
                  state_r   <= DATA;
                  tx_r      <= shift_r[0];
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1'b1);
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  cnt_r <= '0;
                  if (bit_idx_r == 3'd7) begin
`ifdef TX_PARITY_EN
                     state_r <= PARITY;
                     tx_r    <= par_r;
`else
                     state_r <= STOP;
                     tx_r    <= 1'b1;
`endif
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                     tx_r      <= shift_r[bit_idx_r + 3'd1];
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1'b1);
               end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
               if (bit_end_s) begin
                  cnt_r   <= '0;
                  state_r <= STOP;
                  tx_r    <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1'b1);
               end
            end
`endif
            STOP: begin
               if (bit_end_s) begin
                  cnt_r <= '0;
                  if (!ready_r) begin
                     shift_r <= hold_r;
`ifdef TX_PARITY_EN
                     par_r   <= parity_of(hold_r);
`endif
                     state_r <= START;
                     tx_r    <= 1'b0;
                  end else if (accept_s) begin
                     shift_r <= bus.data_in;
`ifdef TX_PARITY_EN
                     par_r   <= parity_of(bus.data_in);
`endif
                     state_r <= START;
                     tx_r    <= 1'b0;
                  end else begin
                     state_r <= IDLE;
                     tx_r    <= 1'b1;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1'b1);
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase

         if (load_hold_s) begin
            hold_r  <= bus.data_in;
            ready_r <= 1'b0;
         end else if ((state_r == STOP) && bit_end_s && !ready_r) begin
            ready_r <= 1'b1;
         end
      end
   end

   assign bus.tx    = tx_r;
   assign bus.busy  = busy_r;
   assign bus.ready = ready_r;
   assign bus.done  = done_r;
endmodule

// File: tb/tb_transmisor.sv
// Self-checking bench for transmisor: directed frames plus randomized traffic against a
// frame-level reference model (active frame, cycle-in-frame, one pending byte).
module tb_transmisor;
   localparam int CPB  = 16;
   localparam bit PODD = 1'b0;
`ifdef TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int F = NBITS * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   transmisor_if bus ();

   transmisor #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Line value in cycle k (1-based) of a frame carrying byte b
   function automatic logic exp_bit(input logic [7:0] b, input int k);
      int idx;
      idx = (k - 1) / CPB;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if ((NBITS == 11) && (idx == 9)) return (^b) ^ PODD;
      return 1'b1;
   endfunction

   // Reference model state
   logic       m_active;
   int         m_k;
   logic [7:0] m_byte;
   logic       m_pend;
   logic [7:0] m_pbyte;
   logic       m_acc;
   logic       e_tx, e_busy, e_done, e_ready;

   assign m_acc = bus.valid && !m_pend;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_k      <= 0;
         m_pend   <= 1'b0;
         m_byte   <= 8'h00;
         m_pbyte  <= 8'h00;
      end else if (m_active && (m_k == F)) begin
         if (m_pend) begin
            m_byte <= m_pbyte;
            m_pend <= 1'b0;
            m_k    <= 1;
         end else if (m_acc) begin
            m_byte <= bus.data_in;
            m_k    <= 1;
         end else begin
            m_active <= 1'b0;
            m_k      <= 0;
         end
      end else if (!m_active) begin
         if (m_acc) begin
            m_active <= 1'b1;
            m_byte   <= bus.data_in;
            m_k      <= 1;
         end
      end else begin
         m_k <= m_k + 1;
         if (m_acc) begin
            m_pend  <= 1'b1;
            m_pbyte <= bus.data_in;
         end
      end
   end

   always_comb begin
      e_tx    = 1'b1;
      e_busy  = m_active;
      e_done  = m_active && (m_k == F);
      e_ready = !m_pend;
      if (m_active) e_tx = exp_bit(m_byte, m_k);
   end

   task automatic test_reset();
      bus.valid   = 1'b0;
      bus.data_in = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.tx, bus.busy, bus.done, bus.ready} !== 4'b1001) begin
         n_fail++;
         $display("FAIL reset_held {tx,busy,done,ready} got %b want 1001", {bus.tx, bus.busy, bus.done, bus.ready});
      end
      rst = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.tx, bus.busy, bus.done, bus.ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL idle_after_reset cyc %0d got %b want 1001", c, {bus.tx, bus.busy, bus.done, bus.ready});
         end
      end
   endtask

   // seq holds the expected line bits of the frame, LSB = start bit
   task automatic test_frame(input logic [7:0] b, input logic [10:0] seq);
      bus.data_in = b;
      bus.valid   = 1'b1;
      for (int c = 1; c <= F + 2; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.tx, bus.busy, bus.done, bus.ready} !== {e_tx, e_busy, e_done, e_ready}) begin
            n_fail++;
            $display("FAIL frame_%h_model cyc %0d got %b want %b", b, c,
                     {bus.tx, bus.busy, bus.done, bus.ready}, {e_tx, e_busy, e_done, e_ready});
         end
         n_checks++;
         if ((bus.done !== (c == F)) || (bus.busy !== (c <= F))) begin
            n_fail++;
            $display("FAIL frame_%h_done_busy cyc %0d got done=%b busy=%b want done=%b busy=%b",
                     b, c, bus.done, bus.busy, (c == F), (c <= F));
         end
         if ((c <= F) && (((c - 1) % CPB) == (CPB / 2))) begin
            n_checks++;
            if (bus.tx !== seq[(c-1)/CPB]) begin
               n_fail++;
               $display("FAIL frame_%h_bit%0d got %b want %b", b, (c-1)/CPB, bus.tx, seq[(c-1)/CPB]);
            end
         end
         if (c == 1) begin
            bus.valid   = 1'b0;
            bus.data_in = 8'($urandom);
         end
      end
   endtask

   task automatic test_back_to_back();
      bus.data_in = 8'h11;
      bus.valid   = 1'b1;
      for (int c = 1; c <= 3 * F + 3; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.tx, bus.busy, bus.done, bus.ready} !== {e_tx, e_busy, e_done, e_ready}) begin
            n_fail++;
            $display("FAIL b2b_model cyc %0d got %b want %b", c,
                     {bus.tx, bus.busy, bus.done, bus.ready}, {e_tx, e_busy, e_done, e_ready});
         end
         if ((c == 2) || (c == F)) begin
            n_checks++;
            if (bus.ready !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_ready_low cyc %0d got %b want 0", c, bus.ready);
            end
         end
         if ((c == F + 1) || (c == 2 * F + 1)) begin
            n_checks++;
            if ({bus.tx, bus.busy} !== 2'b01) begin
               n_fail++;
               $display("FAIL b2b_contiguous cyc %0d {tx,busy} got %b want 01", c, {bus.tx, bus.busy});
            end
         end
         if (c == 3 * F + 1) begin
            n_checks++;
            if ({bus.tx, bus.busy, bus.ready} !== 3'b101) begin
               n_fail++;
               $display("FAIL b2b_end {tx,busy,ready} got %b want 101", {bus.tx, bus.busy, bus.ready});
            end
         end
         if (c == 1) bus.data_in = 8'h22;
         if (c == 2) bus.data_in = 8'h33;
         if (c == F + 2) bus.valid = 1'b0;
      end
   endtask

   task automatic test_reset_mid_frame();
      int tgt;
      tgt = 1 + CPB + 3 * CPB + CPB / 2;
      bus.data_in = 8'hF0;
      bus.valid   = 1'b1;
      for (int c = 1; c <= tgt; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.tx, bus.busy, bus.done, bus.ready} !== {e_tx, e_busy, e_done, e_ready}) begin
            n_fail++;
            $display("FAIL rstmid_model cyc %0d got %b want %b", c,
                     {bus.tx, bus.busy, bus.done, bus.ready}, {e_tx, e_busy, e_done, e_ready});
         end
         if (c == 1) bus.data_in = 8'h0F;
         if (c == 2) bus.valid = 1'b0;
      end
      n_checks++;
      if ({bus.tx, bus.ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL rstmid_pre {tx,ready} got %b want 00", {bus.tx, bus.ready});
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.tx, bus.busy, bus.done, bus.ready} !== 4'b1001) begin
         n_fail++;
         $display("FAIL rstmid_async got %b want 1001", {bus.tx, bus.busy, bus.done, bus.ready});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 2 * F; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.tx, bus.busy, bus.done, bus.ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL rstmid_no_resume cyc %0d got %b want 1001", c, {bus.tx, bus.busy, bus.done, bus.ready});
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.tx, bus.busy, bus.done, bus.ready} !== {e_tx, e_busy, e_done, e_ready}) begin
            n_fail++;
            $display("FAIL random_model cyc %0d got %b want %b", c,
                     {bus.tx, bus.busy, bus.done, bus.ready}, {e_tx, e_busy, e_done, e_ready});
         end
         bus.valid   = ($urandom_range(0, 3) == 0);
         bus.data_in = 8'($urandom);
      end
      bus.valid = 1'b0;
   endtask

   initial begin
      test_reset();
`ifdef TX_PARITY_EN
      test_frame(8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0});
      test_frame(8'h07, {1'b1, 1'b1, 8'h07, 1'b0});
      test_frame(8'h80, {1'b1, 1'b1, 8'h80, 1'b0});
`else
      test_frame(8'hA5, {1'b1, 1'b1, 8'hA5, 1'b0});
      test_frame(8'h07, {1'b1, 1'b1, 8'h07, 1'b0});
      test_frame(8'h80, {1'b1, 1'b1, 8'h80, 1'b0});
`endif
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/transmisor.md
# transmisor

Serial transmitter, the transmit-side counterpart of the project's serial receiver. Accepts 8-bit parallel bytes over a valid/ready handshake and shifts each out on a single idle-high line as a frame: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1). A one-entry holding register lets the next byte be queued during a frame, so frames go back-to-back with no idle gap.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535; baud counter width is $clog2(CLKS_PER_BIT)
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when parity is compiled out
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  8  byte to transmit
- valid  input  1  data_in is presented; a byte transfers on any rising edge where valid && ready
- ready  output  1  transmitter can accept a byte (holding register empty)
- tx  output  1  serial line, registered, idle high
- busy  output  1  high while a frame is on the line (START through STOP)
- done  output  1  one-cycle pulse in the final clk cycle of each stop bit

## Operation
- Reset values: tx=1, busy=0, ready=1, done=0, state=IDLE, holding register empty, counters 0.
- States: IDLE, START, DATA, PARITY, STOP. tx is 1 in IDLE, 0 in START, shift[bit_index] in DATA, the parity bit in PARITY, and 1 in STOP.
- Each of START, PARITY and STOP lasts CLKS_PER_BIT cycles. DATA lasts 8*CLKS_PER_BIT cycles, and bit_index increments 0..7 at each bit boundary.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA.
  - DATA -> PARITY after bit 7. DATA -> STOP instead when parity is compiled out.
  - PARITY -> STOP.
  - STOP -> START if a byte is available, otherwise STOP -> IDLE.
- Byte routing:
  - Bypass: a byte accepted while in IDLE, or on the final STOP cycle with the holding register empty, loads the shift register directly and starts a frame.
  - A byte accepted at any other time goes into the holding register, and ready drops.
  - On the final STOP cycle, a full holding register moves into the shift register and ready rises.
- Parity bit = ^byte XOR PARITY_ODD, computed when the byte is loaded into the shift register.
- Holding register full and valid high: no transfer. data_in is ignored and valid may stay high.
- Reset mid-frame: tx goes to 1 immediately (asynchronous), the frame is aborted, and the holding register is cleared. The partial frame is not resumed.
- data_in may change after the accepting edge; the byte is captured on that edge.

## Timing
- Accept edge E: tx=0 and busy=1 from edge E, i.e. visible in the cycle after E. Latency from accept to start bit is 1 clock.
- Frame length:
  - 11*CLKS_PER_BIT cycles with parity.
  - 10*CLKS_PER_BIT cycles without parity.
- done=1 during the final cycle of STOP only.
- Back-to-back: the next start bit begins on the edge after the final STOP cycle, so there are zero idle cycles between frames.
- ready falls on the edge that loads the holding register and rises on the edge that empties it.
- busy falls on the edge entering IDLE.

## Configuration
- TX_PARITY_EN defined:
  - The PARITY state exists and frames are 11 bits.
  - PARITY_ODD selects even or odd parity.
- TX_PARITY_EN undefined:
  - The PARITY state, the parity register and its logic are removed.
  - DATA goes directly to STOP and frames are 10 bits.
  - PARITY_ODD is accepted but has no effect.

## Test plan
- Reset, no stimulus -> tx=1, ready=1, busy=0, done=0 held for 100 cycles. Assert rst asynchronously between edges -> outputs return to these values before the next edge.
- TX_PARITY_EN, CLKS_PER_BIT=16, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit held 16 cycles. done pulses at cycle 176 after accept. busy low afterwards.
- TX_PARITY_EN, PARITY_ODD=1, send 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 0. With PARITY_ODD=0 -> parity bit 1.
- valid held high with 0x11, 0x22, 0x33 presented in turn:
  - Second byte accepted at the edge after the first accept.
  - ready stays low until the final STOP cycle of frame 1.
  - The three frames are contiguous: no cycle with tx=1 between a stop bit and the next start bit.
- Assert rst during DATA bit 3 of 0xF0, with 0x0F queued -> tx=1 immediately, no further frames, ready=1.
- TX_PARITY_EN undefined, send 0x80 -> 0, 0,0,0,0,0,0,0,1, then stop bit 1. The frame is 160 cycles and done pulses at cycle 160.
